// File: rtl/boiler_stack_renderer.sv
// Boiler sprite with a LIFO stack of colour layers, animated pour/drain and a
// registered RGB565 pixel output for the (X,Y) presented each clock.
module boiler_stack_renderer #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned LAYER_H    = 4,
  parameter int unsigned CW         = 3
) (
  input  logic          CLOCK,
  input  logic          reset,
  input  logic [6:0]    X,
  input  logic [5:0]    Y,
  input  logic [6:0]    leftX,
  input  logic [5:0]    topY,
  input  logic [15:0]   BACKGROUND,
  input  logic          selected,
  input  logic          confirmed,
  input  logic          anim_tick,
  input  logic          push_valid,
  input  logic [CW-1:0] push_colour,
  output logic          push_ready,
  input  logic          pop_valid,
  output logic          pop_ready,
  output logic [CW-1:0] pop_colour,
  output logic [3:0]    count,
  output logic          busy,
  output logic [15:0]   oled_data
);

  localparam int unsigned LVL_W    = 7;
  localparam int unsigned IDX_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned BODY_BOT = 9 + NUM_LAYERS * LAYER_H;

  localparam logic [15:0] C_WHITE      = 16'hFFFF;
  localparam logic [15:0] C_BLACK      = 16'h0000;
  localparam logic [15:0] C_PINK       = 16'hFE19;
  localparam logic [15:0] C_LIGHTGREEN = 16'h9772;
  localparam logic [15:0] C_ORANGE     = 16'hFD20;
  localparam logic [15:0] C_BLUE       = 16'h001F;
  localparam logic [15:0] C_LIGHTBLUE  = 16'hAEDC;
  localparam logic [15:0] C_LIGHTGREY  = 16'hD69A;
  localparam logic [15:0] C_RED        = 16'hF800;
  localparam logic [15:0] C_GREEN      = 16'h07E0;
  localparam logic [15:0] C_BROWN      = 16'hA145;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [3:0]          count_q, count_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [CW-1:0]       stack_q [NUM_LAYERS];
  logic [CW-1:0]       stack_d [NUM_LAYERS];
  logic [15:0]         oled_q, oled_d;

  logic [LVL_W-1:0]    fill_tgt;
  logic [LVL_W-1:0]    top_base;
  logic [IDX_W-1:0]    top_idx;

  assign fill_tgt = LVL_W'(count_q) * LVL_W'(LAYER_H);
  assign top_base = LVL_W'(count_q - 4'd1) * LVL_W'(LAYER_H);
  assign top_idx  = IDX_W'(count_q - 4'd1);

  function automatic logic [15:0] colour_map(input logic [CW-1:0] c);
    case (32'(c))
      0:       colour_map = C_WHITE;
      1:       colour_map = C_PINK;
      2:       colour_map = C_LIGHTGREEN;
      3:       colour_map = C_ORANGE;
      4:       colour_map = C_BLUE;
      5:       colour_map = C_LIGHTBLUE;
      6:       colour_map = C_LIGHTGREY;
      7:       colour_map = C_RED;
      default: colour_map = C_WHITE;
    endcase
  endfunction

  // Next-state: stack handshakes in IDLE, level stepping in FILL/DRAIN
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    level_d    = level_q;
    stack_d    = stack_q;
    push_ready = 1'b0;
    pop_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        push_ready = (count_q < 4'(NUM_LAYERS));
        pop_ready  = (count_q != 4'd0) && !(push_valid && push_ready);
        if (push_valid && push_ready) begin
          stack_d[IDX_W'(count_q)] = push_colour;
          count_d = count_q + 4'd1;
          state_d = FILL;
        end else if (pop_valid && pop_ready) begin
          state_d = DRAIN;
        end
      end
      FILL: begin
        if (level_q == fill_tgt) begin
          state_d = IDLE;
        end else if (anim_tick) begin
          level_d = level_q + LVL_W'(1);
          if (level_d == fill_tgt) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (anim_tick) begin
          level_d = level_q - LVL_W'(1);
          if (level_d == top_base) begin
            count_d          = count_q - 4'd1;
            stack_d[top_idx] = '0;
            state_d          = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop_colour = (count_q != 4'd0) ? stack_q[top_idx] : '0;
  assign busy       = (state_q != IDLE);
  assign count      = count_q;
  assign oled_data  = oled_q;

  logic [7:0]    dx, dy, r;
  logic          outside;
  logic [15:0]   cap_col;

  // Pixel render from sprite-relative coordinates
  always_comb begin
    dx      = 8'(X) - 8'(leftX);
    dy      = 8'(Y) - 8'(topY);
    r       = 8'(BODY_BOT) - dy;
    outside = (X < leftX) || (Y < topY);
    cap_col = confirmed ? C_GREEN : selected ? C_RED : busy ? C_ORANGE : C_BROWN;
    oled_d  = BACKGROUND;
    if (!outside) begin
      if (dy <= 8'd3) begin
        if (dx >= 8'd5 && dx <= 8'd12) oled_d = cap_col;
      end else if (dy <= 8'd9) begin
        if (dx == 8'd6 || dx == 8'd11)     oled_d = C_BLACK;
        else if (dx >= 8'd7 && dx <= 8'd10) oled_d = C_WHITE;
      end else if (dy <= 8'(BODY_BOT)) begin
        if (dx == 8'd0 || dx == 8'd17) begin
          oled_d = C_BLACK;
        end else if (dx >= 8'd1 && dx <= 8'd16) begin
          if (r < 8'(level_q)) oled_d = colour_map(stack_q[IDX_W'(r / 8'(LAYER_H))]);
          else                 oled_d = C_WHITE;
        end
      end else if (dy == 8'(BODY_BOT + 1)) begin
        if (dx <= 8'd17) oled_d = C_BLACK;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      level_q <= '0;
      oled_q  <= '0;
      for (int i = 0; i < int'(NUM_LAYERS); i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      oled_q  <= oled_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: tb/tb_boiler_stack_renderer.sv
// Scoreboard bench for boiler_stack_renderer: a queue-based stack model predicts
// every pixel and handshake; a monitor compares oled_data on the falling edge.
module tb_boiler_stack_renderer;

  localparam int NL = 4;
  localparam int LH = 4;
  localparam int BB = 9 + NL * LH;

  localparam logic [15:0] WHITE = 16'hFFFF, BLACK = 16'h0000, GREEN = 16'h07E0;
  localparam logic [15:0] RED = 16'hF800, ORANGE = 16'hFD20, BROWN = 16'hA145;

  logic        CLOCK = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  X = '0, leftX = '0;
  logic [5:0]  Y = '0, topY = '0;
  logic [15:0] BACKGROUND = 16'h1234;
  logic        selected = 1'b0, confirmed = 1'b0, anim_tick = 1'b0;
  logic        push_valid = 1'b0, pop_valid = 1'b0;
  logic [2:0]  push_colour = '0;
  logic        push_ready, pop_ready, busy;
  logic [2:0]  pop_colour;
  logic [3:0]  count;
  logic [15:0] oled_data;

  boiler_stack_renderer #(.NUM_LAYERS(NL), .LAYER_H(LH), .CW(3)) dut (
    .CLOCK(CLOCK), .reset(reset), .X(X), .Y(Y), .leftX(leftX), .topY(topY),
    .BACKGROUND(BACKGROUND), .selected(selected), .confirmed(confirmed),
    .anim_tick(anim_tick), .push_valid(push_valid), .push_colour(push_colour),
    .push_ready(push_ready), .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_colour(pop_colour), .count(count), .busy(busy), .oled_data(oled_data)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  // Reference model: stack of colours, visible level and the level it heads to
  logic [2:0] stk[$];
  int lvl = 0;
  int tgt = 0;

  function automatic logic [15:0] cmap(input logic [2:0] c);
    case (c)
      3'd0: return WHITE;
      3'd1: return 16'hFE19;
      3'd2: return 16'h9772;
      3'd3: return ORANGE;
      3'd4: return 16'h001F;
      3'd5: return 16'hAEDC;
      3'd6: return 16'hD69A;
      default: return RED;
    endcase
  endfunction

  function automatic bit m_busy();
    return lvl != tgt;
  endfunction

  function automatic bit m_push_ready();
    return !m_busy() && stk.size() < NL;
  endfunction

  function automatic bit m_pop_ready();
    return !m_busy() && stk.size() > 0 && !(push_valid && m_push_ready());
  endfunction

  function automatic logic [15:0] m_pixel();
    int dx, dy, r;
    logic [15:0] cap;
    if (X < leftX || Y < topY) return BACKGROUND;
    dx = int'(X) - int'(leftX);
    dy = int'(Y) - int'(topY);
    cap = confirmed ? GREEN : selected ? RED : m_busy() ? ORANGE : BROWN;
    if (dy <= 3) return (dx >= 5 && dx <= 12) ? cap : BACKGROUND;
    if (dy <= 9) begin
      if (dx == 6 || dx == 11) return BLACK;
      return (dx >= 7 && dx <= 10) ? WHITE : BACKGROUND;
    end
    if (dy <= BB) begin
      if (dx == 0 || dx == 17) return BLACK;
      if (dx > 17) return BACKGROUND;
      r = BB - dy;
      return (r < lvl) ? cmap(stk[r / LH]) : WHITE;
    end
    if (dy == BB + 1 && dx <= 17) return BLACK;
    return BACKGROUND;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one registered pixel per clock, compared against the oldest prediction
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge CLOCK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (oled_data !== e) begin
          errors++;
          $display("FAIL pixel: got %h expected %h at %0t", oled_data, e, $time);
        end
      end
    end
  end

  // One clock: check handshakes, predict the pixel, then advance the model
  task automatic step();
    logic [15:0] e;
    bit pa, qa, tk;
    #1;
    if (!reset) begin
      chk("push_ready", 16'(push_ready), 16'(m_push_ready()));
      chk("pop_ready", 16'(pop_ready), 16'(m_pop_ready()));
      chk("count", 16'(count), 16'(stk.size()));
      chk("busy", 16'(busy), 16'(m_busy()));
      chk("pop_colour", 16'(pop_colour), stk.size() > 0 ? 16'(stk[$]) : 16'h0);
    end
    e  = reset ? 16'h0 : m_pixel();
    pa = push_valid && m_push_ready();
    qa = pop_valid && m_pop_ready();
    tk = anim_tick;
    @(posedge CLOCK);
    exp_q.push_back(e);
    if (reset) begin
      stk.delete(); lvl = 0; tgt = 0;
    end else if (lvl != tgt) begin
      if (tk) begin
        if (tgt > lvl) lvl++;
        else begin
          lvl--;
          if (lvl == tgt) void'(stk.pop_back());
        end
      end
    end else if (pa) begin
      stk.push_back(push_colour);
      tgt = stk.size() * LH;
    end else if (qa) begin
      tgt = (stk.size() - 1) * LH;
    end
    #1;
  endtask

  task automatic rand_pix();
    int oy;
    X  = 7'((int'(leftX) + $urandom_range(0, 20) + 127) % 128);
    oy = int'(topY) + $urandom_range(0, BB + 3) - 1;
    Y  = (oy < 0 || oy > 63) ? 6'($urandom_range(0, 63)) : 6'(oy);
  endtask

  task automatic do_reset();
    reset = 1'b1; push_valid = 1'b0; pop_valid = 1'b0; anim_tick = 1'b0;
    rand_pix(); step(); step();
    reset = 1'b0;
  endtask

  task automatic scan_col(input int dx);
    anim_tick = 1'b0;
    for (int dy = 0; dy <= BB + 2; dy++) begin
      X = 7'(int'(leftX) + dx);
      Y = 6'((int'(topY) + dy) % 64);
      step();
    end
  endtask

  // Handshake with a tick in the same cycle, then animate until settled
  task automatic push_and_fill(input logic [2:0] c);
    push_valid = 1'b1; push_colour = c; anim_tick = 1'b1; rand_pix(); step();
    push_valid = 1'b0;
    for (int n = 0; n < 200 && m_busy(); n++) begin
      anim_tick = 1'($urandom_range(0, 1)); rand_pix(); step();
    end
    if (m_busy()) chk("fill_timeout", 16'(busy), 16'h0);
  endtask

  initial begin
    leftX = 7'd20; topY = 6'd5;
    @(posedge CLOCK); #1;
    do_reset();
    // T1: idle cap
    X = leftX + 7'd8; Y = topY + 6'd1; step(); step();
    // T2: single blue layer, full column scan
    push_and_fill(3'd4);
    scan_col(5); scan_col(0); scan_col(9);
    // T3: fill to capacity, extra push refused
    do_reset();
    push_and_fill(3'd1); push_and_fill(3'd2); push_and_fill(3'd3); push_and_fill(3'd5);
    push_valid = 1'b1; push_colour = 3'd6; rand_pix(); step(); step();
    push_valid = 1'b0;
    scan_col(8);
    // T4: simultaneous push and pop with two layers
    do_reset();
    push_and_fill(3'd7); push_and_fill(3'd6);
    push_valid = 1'b1; pop_valid = 1'b1; push_colour = 3'd2; rand_pix(); step();
    push_valid = 1'b0; pop_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin anim_tick = 1'b1; rand_pix(); step(); end
    // T5: pop with handshake tick, pop held during drain
    pop_valid = 1'b1; anim_tick = 1'b1; rand_pix(); step();
    for (int n = 0; n < LH + 2; n++) begin
      anim_tick = (n < LH - 1) ? 1'b1 : 1'b0; rand_pix(); step();
    end
    pop_valid = 1'b0; anim_tick = 1'b1; rand_pix(); step();
    scan_col(3);
    // T6: reset mid-fill
    push_valid = 1'b1; push_colour = 3'd3; step();
    push_valid = 1'b0; anim_tick = 1'b1; step(); step();
    do_reset();
    scan_col(4);
    // Random traffic with occasional reset and sprite moves
    for (int n = 0; n < 1500; n++) begin
      push_valid  = ($urandom_range(0, 3) == 0);
      pop_valid   = ($urandom_range(0, 3) == 0);
      push_colour = 3'($urandom_range(0, 7));
      anim_tick   = 1'($urandom_range(0, 1));
      selected    = ($urandom_range(0, 5) == 0);
      confirmed   = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) begin
        leftX = 7'($urandom_range(0, 78));
        topY  = 6'($urandom_range(0, 63 - BB - 1));
        BACKGROUND = 16'($urandom);
      end
      rand_pix();
      step();
    end
    reset = 1'b0; push_valid = 1'b0; pop_valid = 1'b0;
    @(negedge CLOCK); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
